// File: rtl/usb_pkg.sv
// Shared USB host definitions: packet IDs, engine states and default token addressing.
package usb_pkg;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_DATA0 = 4'b0011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010
    } pid_t;

    typedef enum logic [2:0] {
        IDLE,
        TX_TOKEN,
        TX_DATA,
        WAIT_HS,
        WAIT_DATA,
        TX_HS
    } state_t;

    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'd5;
    localparam logic [3:0] DEFAULT_ENDP_OUT = 4'd4;
    localparam logic [3:0] DEFAULT_ENDP_IN  = 4'd8;

    function automatic pid_t token_pid(input logic is_out);
        return is_out ? PID_OUT : PID_IN;
    endfunction

endpackage

// File: rtl/usb_timeout_timer.sv
// Wait-state watchdog: counts enabled cycles from a cleared start and flags the last allowed one.
module usb_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int             W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0]   LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/usb_protocol_fsm.sv
// Transaction-level USB host engine: token / data / handshake exchange with retry on NAK,
// corruption or timeout, reporting a one-cycle success or failure pulse.
module usb_protocol_fsm
    import usb_pkg::*;
#(
    parameter int         MAX_RETRY      = 8,
    parameter int         TIMEOUT_CYCLES = 255,
    parameter logic [6:0] DEV_ADDR       = DEFAULT_DEV_ADDR,
    parameter logic [3:0] ENDP_OUT       = DEFAULT_ENDP_OUT,
    parameter logic [3:0] ENDP_IN        = DEFAULT_ENDP_IN
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        in_trans,
    input  logic        out_trans,
    input  logic [63:0] data_to_device,
    output logic        success,
    output logic        failure,
    output logic [63:0] data_from_device,
    output logic        tx_start,
    output logic [3:0]  tx_pid,
    output logic [6:0]  tx_addr,
    output logic [3:0]  tx_endp,
    output logic [63:0] tx_data,
    input  logic        tx_done,
    input  logic        rx_valid,
    input  logic [3:0]  rx_pid,
    input  logic [63:0] rx_data,
    input  logic        rx_error
);

    localparam int                 RETRY_W    = $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] LAST_RETRY = RETRY_W'(MAX_RETRY - 1);

    state_t             state;
    logic               is_out;
    logic [63:0]        payload;
    logic [RETRY_W-1:0] retry_cnt;
    logic               in_wait;
    logic               expired;
    logic               attempt_lost;

    assign in_wait = (state == WAIT_HS) || (state == WAIT_DATA);

    // Held clear outside the wait states, so every wait-state entry starts from zero.
    usb_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_b  (rst_b),
        .clear  (!in_wait),
        .enable (in_wait),
        .expired(expired)
    );

    // NOTE: the default assignment at the top keeps this block free of inferred latches.
    always_comb begin
        attempt_lost = 1'b0;
        case (state)
            WAIT_HS:   attempt_lost = rx_valid ? !(rx_pid == PID_ACK && !rx_error) : expired;
            WAIT_DATA: attempt_lost = !rx_valid && expired;
            TX_HS:     attempt_lost = tx_done && (tx_pid != PID_ACK);
            default:   attempt_lost = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state            <= IDLE;
            is_out           <= 1'b0;
            payload          <= '0;
            retry_cnt        <= '0;
            success          <= 1'b0;
            failure          <= 1'b0;
            data_from_device <= '0;
            tx_start         <= 1'b0;
            tx_pid           <= '0;
            tx_addr          <= '0;
            tx_endp          <= '0;
            tx_data          <= '0;
        end else begin
            success  <= 1'b0;
            failure  <= 1'b0;
            tx_start <= 1'b0;

            case (state)
                IDLE: begin
                    if (out_trans || in_trans) begin
                        is_out    <= out_trans;
                        retry_cnt <= '0;
                        if (out_trans) payload <= data_to_device;
                        state     <= TX_TOKEN;
                        tx_start  <= 1'b1;
                        tx_pid    <= token_pid(out_trans);
                        tx_addr   <= DEV_ADDR;
                        tx_endp   <= out_trans ? ENDP_OUT : ENDP_IN;
                    end
                end
                TX_TOKEN: begin
                    if (tx_done) begin
                        if (is_out) begin
                            state    <= TX_DATA;
                            tx_start <= 1'b1;
                            tx_pid   <= PID_DATA0;
                            tx_data  <= payload;
                        end else begin
                            state <= WAIT_DATA;
                        end
                    end
                end
                TX_DATA: begin
                    if (tx_done) state <= WAIT_HS;
                end
                WAIT_HS: begin
                    if (rx_valid && !attempt_lost) begin
                        success <= 1'b1;
                        state   <= IDLE;
                    end
                end
                WAIT_DATA: begin
                    if (rx_valid) begin
                        state    <= TX_HS;
                        tx_start <= 1'b1;
                        if (rx_pid == PID_DATA0 && !rx_error) begin
                            data_from_device <= rx_data;
                            tx_pid           <= PID_ACK;
                        end else begin
                            tx_pid <= PID_NAK;
                        end
                    end
                end
                TX_HS: begin
                    if (tx_done && !attempt_lost) begin
                        success <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A lost attempt overrides the per-state decisions above.
            if (attempt_lost) begin
                retry_cnt <= retry_cnt + 1'b1;
                if (retry_cnt == LAST_RETRY) begin
                    failure <= 1'b1;
                    state   <= IDLE;
                end else begin
                    state    <= TX_TOKEN;
                    tx_start <= 1'b1;
                    tx_pid   <= token_pid(is_out);
                    tx_addr  <= DEV_ADDR;
                    tx_endp  <= is_out ? ENDP_OUT : ENDP_IN;
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_protocol_fsm.sv
// Bench for usb_protocol_fsm: encoder/device responder driven by a per-attempt response script,
// compared against a transaction-level model of the expected packet sequence and outcome.
module tb_usb_protocol_fsm;

    localparam logic [3:0] P_OUT = 4'b0001, P_IN = 4'b1001, P_DATA0 = 4'b0011,
                           P_ACK = 4'b0010, P_NAK = 4'b1010;
    localparam int RETRIES = 8;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        in_trans = 1'b0, out_trans = 1'b0;
    logic [63:0] data_to_device = '0;
    logic        success, failure;
    logic [63:0] data_from_device;
    logic        tx_start;
    logic [3:0]  tx_pid;
    logic [6:0]  tx_addr;
    logic [3:0]  tx_endp;
    logic [63:0] tx_data;
    logic        tx_done = 1'b0;
    logic        rx_valid = 1'b0;
    logic [3:0]  rx_pid = '0;
    logic [63:0] rx_data = '0;
    logic        rx_error = 1'b0;

    usb_protocol_fsm dut (
        .clk(clk), .rst_b(rst_b), .in_trans(in_trans), .out_trans(out_trans),
        .data_to_device(data_to_device), .success(success), .failure(failure),
        .data_from_device(data_from_device), .tx_start(tx_start), .tx_pid(tx_pid),
        .tx_addr(tx_addr), .tx_endp(tx_endp), .tx_data(tx_data), .tx_done(tx_done),
        .rx_valid(rx_valid), .rx_pid(rx_pid), .rx_data(rx_data), .rx_error(rx_error)
    );

    always #5 clk = ~clk;

    int          n_checks = 0, n_errors = 0;
    string       script = "";
    int          rsp_idx = 0, rsp_delay = 0, enc_lat = 1, epoch = 0;
    logic [63:0] in_payload = '0, cur_payload = '0, exp_dfd = '0;
    logic [3:0]  sent_q[$];
    int          succ_cnt = 0, fail_cnt = 0;
    logic [63:0] dfd_at_succ = '0;
    logic        prev_succ = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: packet log, token/data field checks and pulse bookkeeping.
    always @(negedge clk) begin
        if (rst_b) begin
            if (tx_start) begin
                sent_q.push_back(tx_pid);
                if (tx_pid == P_OUT || tx_pid == P_IN) begin
                    check("token_addr", tx_addr, 7'd5);
                    check("token_endp", tx_endp, (tx_pid == P_OUT) ? 4'd4 : 4'd8);
                end
                if (tx_pid == P_DATA0) check("tx_data", tx_data, cur_payload);
            end
            if (success || failure) check("pulse_exclusive", success & failure, 1'b0);
            if (success) begin
                succ_cnt++;
                dfd_at_succ = data_from_device;
                check("success_width", prev_succ, 1'b0);
            end
            if (failure) fail_cnt++;
        end
        prev_succ = success;
    end

    // Device side: one scripted reaction per attempt ('G' good, 'N' NAK, 'B' wrong PID, 'E' rx_error, 'T' silence).
    task automatic respond(input bit in_tok, input int ep);
        byte r;
        r = (rsp_idx < script.len()) ? script[rsp_idx] : "G";
        rsp_idx++;
        if (r == "T") return;
        repeat (rsp_delay) @(negedge clk);
        if (ep != epoch) return;
        rx_valid = 1'b1;
        rx_error = (r == "E");
        rx_data  = {$urandom, $urandom};
        if (in_tok) begin
            rx_pid = (r == "N") ? P_NAK : (r == "B") ? P_ACK : P_DATA0;
            if (r == "G") rx_data = in_payload;
        end else begin
            rx_pid = (r == "N") ? P_NAK : (r == "B") ? P_DATA0 : P_ACK;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic serve_packet();
        logic [3:0] pid;
        int         ep;
        pid = tx_pid;
        ep  = epoch;
        repeat (enc_lat) @(negedge clk);
        if (ep != epoch || !rst_b) return;
        check("tx_pid_held", tx_pid, pid);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        if (ep == epoch && (pid == P_DATA0 || pid == P_IN)) respond(pid == P_IN, ep);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (rst_b && tx_start) serve_packet();
        end
    end

    task automatic run_trans(input bit ro, input bit ri, input logic [63:0] pay, input string scr,
                             input int dly, input int lat, input bit stray);
        int budget;
        sent_q.delete();
        succ_cnt = 0; fail_cnt = 0; dfd_at_succ = '0;
        script = scr; rsp_idx = 0; rsp_delay = dly; enc_lat = lat;
        cur_payload = pay; in_payload = pay;
        @(posedge clk); #1;
        out_trans = ro; in_trans = ri;
        data_to_device = ro ? pay : ~pay;
        @(posedge clk); #1;
        out_trans = 1'b0; in_trans = 1'b0;
        data_to_device = {$urandom, $urandom};
        if (stray) begin
            @(posedge clk); @(posedge clk); #1;
            out_trans = 1'b1; in_trans = 1'b1;
            @(posedge clk); #1;
            out_trans = 1'b0; in_trans = 1'b0;
        end
        budget = 5000;
        while ((succ_cnt + fail_cnt) == 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("done_within_budget", budget > 0, 1'b1);
        repeat (6) @(negedge clk);
    endtask

    // Reference: each attempt consumes one script entry; 8 lost attempts end in failure.
    task automatic check_model(input bit is_out, input string scr);
        logic [3:0] exp_q[$];
        bit  ok = 1'b0;
        int  lost = 0, idx = 0;
        byte r;
        while (!ok && lost < RETRIES) begin
            r = (idx < scr.len()) ? scr[idx] : "G";
            idx++;
            if (is_out) begin
                exp_q.push_back(P_OUT);
                exp_q.push_back(P_DATA0);
                ok = (r == "G");
            end else begin
                exp_q.push_back(P_IN);
                if (r == "G") begin
                    exp_q.push_back(P_ACK);
                    ok = 1'b1;
                end else if (r != "T") begin
                    exp_q.push_back(P_NAK);
                end
            end
            if (!ok) lost++;
        end
        check("packet_count", sent_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) check("packet_pid", sent_q[i], exp_q[i]);
        check("success_pulses", succ_cnt, ok);
        check("failure_pulses", fail_cnt, !ok);
        if (ok && !is_out) begin
            exp_dfd = in_payload;
            check("dfd_with_success", dfd_at_succ, exp_dfd);
        end
        check("data_from_device", data_from_device, exp_dfd);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_success"}, success, 1'b0);
        check({tag, "_failure"}, failure, 1'b0);
        check({tag, "_dfd"}, data_from_device, 64'h0);
        check({tag, "_tx_start"}, tx_start, 1'b0);
        check({tag, "_tx_pid"}, tx_pid, 4'h0);
        check({tag, "_tx_addr"}, tx_addr, 7'h0);
        check({tag, "_tx_endp"}, tx_endp, 4'h0);
        check({tag, "_tx_data"}, tx_data, 64'h0);
    endtask

    typedef struct {
        bit          ro;
        bit          ri;
        logic [63:0] pay;
        string       scr;
        int          dly;
        int          exp_tok;
        bit          exp_ok;
        logic [63:0] exp_dfd;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int  tok;
        int  budget;
        bit  used_t;
        string scr;
        int  pick;

        vecs[0]  = '{1'b1, 1'b0, 64'h1234,                "G",        2,   1, 1'b1, 64'h0};
        vecs[1]  = '{1'b1, 1'b0, 64'hA5A5_0000_FFFF_1111, "NNNG",     1,   4, 1'b1, 64'h0};
        vecs[2]  = '{1'b1, 1'b0, 64'h0BAD,                "NNNNNNNN", 0,   8, 1'b0, 64'h0};
        vecs[3]  = '{1'b1, 1'b0, 64'h7777,                "G",        0,   1, 1'b1, 64'h0};
        vecs[4]  = '{1'b0, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, "G",        3,   1, 1'b1, 64'hDEAD_BEEF_CAFE_F00D};
        vecs[5]  = '{1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, "ETG",      1,   3, 1'b1, 64'h0123_4567_89AB_CDEF};
        vecs[6]  = '{1'b1, 1'b1, 64'h5555,                "G",        1,   1, 1'b1, 64'h0123_4567_89AB_CDEF};
        vecs[7]  = '{1'b0, 1'b1, 64'h1111,                "NBEEEEEE", 2,   8, 1'b0, 64'h0123_4567_89AB_CDEF};
        vecs[8]  = '{1'b1, 1'b0, 64'h9999,                "G",        254, 1, 1'b1, 64'h0123_4567_89AB_CDEF};
        vecs[9]  = '{1'b0, 1'b1, 64'h4242,                "BG",       0,   2, 1'b1, 64'h4242};
        vecs[10] = '{1'b1, 1'b0, 64'h3,                   "TEBG",     0,   4, 1'b1, 64'h4242};

        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_b = 1'b1;

        foreach (vecs[v]) begin
            run_trans(vecs[v].ro, vecs[v].ri, vecs[v].pay, vecs[v].scr, vecs[v].dly, 1 + (v % 3), 1'b0);
            tok = 0;
            foreach (sent_q[i]) if (sent_q[i] == P_OUT || sent_q[i] == P_IN) tok++;
            check($sformatf("vec%0d_tokens", v), tok, vecs[v].exp_tok);
            check($sformatf("vec%0d_success", v), succ_cnt, vecs[v].exp_ok);
            check($sformatf("vec%0d_failure", v), fail_cnt, !vecs[v].exp_ok);
            check($sformatf("vec%0d_first_pid", v), (sent_q.size() > 0) ? sent_q[0] : 4'hF,
                  vecs[v].ro ? P_OUT : P_IN);
            check_model(vecs[v].ro, vecs[v].scr);
            check($sformatf("vec%0d_dfd", v), data_from_device, vecs[v].exp_dfd);
        end

        // Reset while waiting for a handshake: abandon silently, then a fresh IN completes.
        sent_q.delete();
        succ_cnt = 0; fail_cnt = 0;
        script = "T"; rsp_idx = 0; enc_lat = 1; rsp_delay = 0; cur_payload = 64'hFACE;
        @(posedge clk); #1;
        out_trans = 1'b1; data_to_device = 64'hFACE;
        @(posedge clk); #1;
        out_trans = 1'b0;
        budget = 100;
        while (sent_q.size() < 2 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("reset_seq_reached_wait", budget > 0, 1'b1);
        repeat (10) @(negedge clk);
        #3;
        rst_b = 1'b0;
        epoch++;
        #1;
        check_all_zero("async_reset");
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        exp_dfd = '0;
        repeat (300) @(negedge clk);
        check("reset_no_success", succ_cnt, 0);
        check("reset_no_failure", fail_cnt, 0);
        check("reset_no_new_packets", sent_q.size(), 2);
        run_trans(1'b0, 1'b1, 64'hC0FF_EE00_1234_5678, "G", 1, 1, 1'b0);
        check_model(1'b0, "G");

        // Randomised transactions with stray requests while busy.
        for (int t = 0; t < 30; t++) begin
            bit ro, ri;
            pick = $urandom_range(0, 2);
            ro = (pick != 1);
            ri = (pick != 0);
            scr = "";
            used_t = 1'b0;
            for (int k = $urandom_range(0, 9); k > 0; k--) begin
                pick = $urandom_range(0, 9);
                if (pick <= 2)      scr = {scr, "G"};
                else if (pick <= 5) scr = {scr, "N"};
                else if (pick <= 7) scr = {scr, "B"};
                else if (pick == 9 && !used_t) begin
                    scr = {scr, "T"};
                    used_t = 1'b1;
                end else scr = {scr, "E"};
            end
            run_trans(ro, ri, {$urandom, $urandom}, scr, $urandom_range(0, 4),
                      $urandom_range(1, 3), 1'($urandom_range(0, 1)));
            check_model(ro, scr);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
